wb_reg_file: RTL and testbench

WB_REG_FILE -- requirements
Module: wb_reg_file

---
 rtl/wb_reg_file.sv | 86 ++++++++
 tb/tb_wb_reg_file.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_file.sv
// wb_reg_file: 32 x 32-bit register file with a writeback-source mux,
// write-through read bypass and a saturating committed-write counter.
//
// Ports
//   clk, reset         : clock; synchronous active-high reset
//   i_reg_write        : writeback enable
//   i_mem_to_reg[1:0]  : writeback source select (result/load/pc+4/imm)
//   i_write_register   : destination register index
//   i_result, i_mem_read_data, i_pc_4, i_imm_ext_out : writeback sources
//   i_rs, i_rt         : read addresses A/B
//   o_rs_data, o_rt_data : read data A/B (combinational, bypassed)
//   o_wb_data          : selected writeback value (combinational)
//   o_wb_commit        : a real write happens this cycle (combinational)
//   o_write_count      : saturating count of committed writes
module wb_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_reg_write,
  input  logic [1:0]  i_mem_to_reg,
  input  logic [4:0]  i_write_register,
  input  logic [31:0] i_result,
  input  logic [31:0] i_mem_read_data,
  input  logic [31:0] i_pc_4,
  input  logic [31:0] i_imm_ext_out,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  output logic [31:0] o_rs_data,
  output logic [31:0] o_rt_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_commit,
  output logic [31:0] o_write_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  logic [DATA_W-1:0] mem [NREGS];
  logic [DATA_W-1:0] write_count;

  // Writeback source select
  always_comb begin
    o_wb_data = i_result;
    unique case (i_mem_to_reg)
      2'b00:   o_wb_data = i_result;
      2'b01:   o_wb_data = i_mem_read_data;
      2'b10:   o_wb_data = i_pc_4;
      default: o_wb_data = i_imm_ext_out;
    endcase
  end

  // Writes to register 0 are not real writes
  assign o_wb_commit = i_reg_write && (i_write_register != ADDR_W'(0));

  // Read ports: register 0 is hard zero, then same-cycle bypass, then storage
  always_comb begin
    o_rs_data = mem[i_rs];
    if (i_rs == ADDR_W'(0))
      o_rs_data = '0;
    else if (o_wb_commit && (i_rs == i_write_register))
      o_rs_data = o_wb_data;
  end

  always_comb begin
    o_rt_data = mem[i_rt];
    if (i_rt == ADDR_W'(0))
      o_rt_data = '0;
    else if (o_wb_commit && (i_rt == i_write_register))
      o_rt_data = o_wb_data;
  end

  // Storage and commit counter; reset wins over a simultaneous commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      write_count <= '0;
    end else if (o_wb_commit) begin
      mem[i_write_register] <= o_wb_data;
      if (write_count != '1)
        write_count <= write_count + DATA_W'(1);
    end
  end

  assign o_write_count = write_count;

endmodule

// File: tb/tb_wb_reg_file.sv
// Self-checking bench for wb_reg_file: a driver issues one stimulus vector per
// cycle and pushes the expected outputs computed by a reference model; a
// monitor pops and compares on the falling edge.
module tb_wb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_reg_write;
  logic [1:0]  i_mem_to_reg;
  logic [4:0]  i_write_register;
  logic [31:0] i_result, i_mem_read_data, i_pc_4, i_imm_ext_out;
  logic [4:0]  i_rs, i_rt;
  logic [31:0] o_rs_data, o_rt_data, o_wb_data, o_write_count;
  logic        o_wb_commit;

  wb_reg_file dut (
    .clk(clk), .reset(reset),
    .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg),
    .i_write_register(i_write_register), .i_result(i_result),
    .i_mem_read_data(i_mem_read_data), .i_pc_4(i_pc_4),
    .i_imm_ext_out(i_imm_ext_out), .i_rs(i_rs), .i_rt(i_rt),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_wb_data(o_wb_data),
    .o_wb_commit(o_wb_commit), .o_write_count(o_write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] wb;
    logic        commit;
    logic [31:0] cnt;
    bit          state_known;
    int          id;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state
  logic [31:0]    model_regs [32];
  longint unsigned model_cnt = 0;
  bit             model_known = 0;
  int             vec_id = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, id, act, exp);
    end
  endtask

  // Monitor: combinational outputs are presented every cycle; sample mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("wb_data", e.id, o_wb_data, e.wb);
      chk("wb_commit", e.id, 32'(o_wb_commit), 32'(e.commit));
      chk("rs_data", e.id, o_rs_data, e.rs);
      chk("rt_data", e.id, o_rt_data, e.rt);
      if (e.state_known) chk("write_count", e.id, o_write_count, e.cnt);
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit cm,
                                             input logic [4:0] wr, input logic [31:0] wb);
    if (a == 5'd0) return 32'h0;
    if (cm && a == wr) return wb;
    return model_regs[a];
  endfunction

  // Drive one cycle of inputs just after the rising edge, queue the
  // expectation, then advance the model to the state after the next edge.
  task automatic cycle(input bit rst, input bit we, input logic [1:0] sel,
                       input logic [4:0] wr, input logic [31:0] res,
                       input logic [31:0] mrd, input logic [31:0] pc4,
                       input logic [31:0] imm, input logic [4:0] rs,
                       input logic [4:0] rt, input bit frc);
    exp_t e;
    logic [31:0] wb;
    bit cm;
    @(posedge clk);
    #1;
    reset = rst; i_reg_write = we; i_mem_to_reg = sel; i_write_register = wr;
    i_result = res; i_mem_read_data = mrd; i_pc_4 = pc4; i_imm_ext_out = imm;
    i_rs = rs; i_rt = rt;
    if (frc) begin
      force dut.write_count = 32'hFFFF_FFFE;
      release dut.write_count;
      model_cnt = 64'hFFFF_FFFE;
    end
    case (sel)
      2'd0: wb = res;
      2'd1: wb = mrd;
      2'd2: wb = pc4;
      default: wb = imm;
    endcase
    cm = we && (wr != 5'd0);
    e.wb = wb; e.commit = cm;
    e.rs = model_read(rs, cm, wr, wb);
    e.rt = model_read(rt, cm, wr, wb);
    e.cnt = 32'(model_cnt);
    e.state_known = model_known;
    e.id = vec_id++;
    q.push_back(e);
    if (rst) begin
      foreach (model_regs[i]) model_regs[i] = 32'h0;
      model_cnt = 0;
      model_known = 1;
    end else if (cm) begin
      model_regs[wr] = wb;
      if (model_cnt < 64'hFFFF_FFFF) model_cnt++;
    end
  endtask

  task automatic wr_res(input logic [4:0] wr, input logic [31:0] v,
                        input logic [4:0] rs, input logic [4:0] rt);
    cycle(0, 1, 2'd0, wr, v, 32'h0, 32'h0, 32'h0, rs, rt, 0);
  endtask

  task automatic rd(input logic [4:0] rs, input logic [4:0] rt);
    cycle(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, rs, rt, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (model_regs[i]) model_regs[i] = 32'h0;
    reset = 1; i_reg_write = 0; i_mem_to_reg = 0; i_write_register = 0;
    i_result = 0; i_mem_read_data = 0; i_pc_4 = 0; i_imm_ext_out = 0;
    i_rs = 0; i_rt = 0;

    // Reset for two cycles, then everything reads zero
    cycle(1, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0);
    cycle(1, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0);
    rd(5'd5, 5'd31);

    // Basic write/read
    wr_res(5'd5, 32'h1234_5678, 5'd0, 5'd0);
    rd(5'd5, 5'd0);

    // Source select on reg 7
    for (int s = 0; s < 4; s++) begin
      cycle(0, 1, 2'(s), 5'd7, 32'hAAAA_0001, 32'hBBBB_0002, 32'h0040_0010,
            32'hFFFF_8000, 5'd7, 5'd7, 0);
      rd(5'd7, 5'd7);
    end

    // Same-cycle bypass on both ports
    wr_res(5'd9, 32'h0000_0011, 5'd0, 5'd0);
    wr_res(5'd9, 32'h0000_0022, 5'd9, 5'd9);
    rd(5'd9, 5'd9);

    // Register zero is never written, bypassed, or counted
    wr_res(5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    rd(5'd0, 5'd0);

    // Reset wins over a simultaneous commit
    wr_res(5'd3, 32'h55, 5'd0, 5'd0);
    cycle(1, 1, 2'd0, 5'd4, 32'h66, 32'h0, 32'h0, 32'h0, 5'd3, 5'd4, 0);
    rd(5'd3, 5'd4);

    // Randomized traffic, biased toward a few registers to hit bypass often
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr, rs, rt;
      bit rst;
      wr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      rs = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 3));
      rt = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      cycle(rst, 1'($urandom), 2'($urandom), wr, $urandom, $urandom, $urandom,
            $urandom, rs, rt, 0);
    end

    // Counter saturation
    cycle(0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1);
    wr_res(5'd10, 32'h1, 5'd10, 5'd0);
    wr_res(5'd11, 32'h2, 5'd10, 5'd11);
    wr_res(5'd12, 32'h3, 5'd11, 5'd12);
    rd(5'd12, 5'd10);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
